// File: rtl/phase_timer_fsm.sv
// Two-phase HIGH/LOW timer driven by a prescaled tick.
// One-shot or continuous operation with start, stop and pause.
module phase_timer_fsm #(
    parameter int PRESCALE_DIV = 103,
    parameter int PRESCALE_W   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             EN,
    input  logic             MODE,
    input  logic             START,
    input  logic             STOP,
    input  logic [CNT_W-1:0] HI_LEN,
    input  logic [CNT_W-1:0] LO_LEN,
    output logic             TICK,
    output logic             PHASE,
    output logic [CNT_W-1:0] CNT,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t                state_q;
    logic [PRESCALE_W-1:0] pre_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      len_q;
    logic                  phase_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mode_q;

    logic                  pre_last;
    logic                  len_end;
    logic [CNT_W-1:0]      hi_eff;
    logic [CNT_W-1:0]      lo_eff;

    assign pre_last = (pre_q == PRESCALE_W'(PRESCALE_DIV - 1));
    assign len_end  = (cnt_q == len_q - CNT_W'(1));
    assign hi_eff   = (HI_LEN == '0) ? CNT_W'(1) : HI_LEN;
    assign lo_eff   = (LO_LEN == '0) ? CNT_W'(1) : LO_LEN;

    assign TICK  = EN & busy_q & pre_last;
    assign PHASE = phase_q;
    assign CNT   = cnt_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

    // len_q holds the length of whichever phase is active.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else if (STOP) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (START && EN) begin
                        state_q <= S_HIGH;
                        pre_q   <= '0;
                        cnt_q   <= '0;
                        len_q   <= hi_eff;
                        mode_q  <= MODE;
                        phase_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (EN) begin
                        pre_q <= pre_last ? '0 : pre_q + PRESCALE_W'(1);
                        if (pre_last) begin
                            if (len_end) begin
                                state_q <= S_LOW;
                                cnt_q   <= '0;
                                len_q   <= lo_eff;
                                phase_q <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                S_LOW: begin
                    if (EN) begin
                        pre_q <= pre_last ? '0 : pre_q + PRESCALE_W'(1);
                        if (pre_last) begin
                            if (len_end) begin
                                done_q <= 1'b1;
                                cnt_q  <= '0;
                                if (mode_q) begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                end else begin
                                    state_q <= S_HIGH;
                                    len_q   <= hi_eff;
                                    phase_q <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    phase_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_timer_fsm.sv
// Scoreboard bench for phase_timer_fsm with PRESCALE_DIV=4.
// Stimulus queues cycle-stamped expectations; a negedge monitor checks them.
module tb_phase_timer_fsm;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       EN = 1'b0;
    logic       MODE = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic [3:0] HI_LEN = 4'd0;
    logic [3:0] LO_LEN = 4'd0;
    logic       TICK;
    logic       PHASE;
    logic [3:0] CNT;
    logic       BUSY;
    logic       DONE;

    phase_timer_fsm #(
        .PRESCALE_DIV(4),
        .PRESCALE_W  (8),
        .CNT_W       (4)
    ) dut (
        .CLK   (CLK),
        .RESETN(RESETN),
        .EN    (EN),
        .MODE  (MODE),
        .START (START),
        .STOP  (STOP),
        .HI_LEN(HI_LEN),
        .LO_LEN(LO_LEN),
        .TICK  (TICK),
        .PHASE (PHASE),
        .CNT   (CNT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        string      name;
        logic       ph;
        logic       bu;
        logic       dn;
        logic       tk;
        logic [3:0] ct;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   b;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic push(input int c, input string n, input logic ph,
                        input logic bu, input logic dn, input logic tk,
                        input logic [3:0] ct);
        exp_t e;
        e.cyc = c;
        e.name = n;
        e.ph = ph;
        e.bu = bu;
        e.dn = dn;
        e.tk = tk;
        e.ct = ct;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            if (q[0].cyc == cyc) begin
                m_e = q.pop_front();
                total++;
                if ({PHASE, BUSY, DONE, TICK, CNT} !==
                    {m_e.ph, m_e.bu, m_e.dn, m_e.tk, m_e.ct}) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got ph=%b bu=%b dn=%b tk=%b cnt=%0d exp ph=%b bu=%b dn=%b tk=%b cnt=%0d",
                             m_e.name, cyc, PHASE, BUSY, DONE, TICK, CNT,
                             m_e.ph, m_e.bu, m_e.dn, m_e.tk, m_e.ct);
                end
            end else if (q[0].cyc < cyc) begin
                m_e = q.pop_front();
                total++;
                bad++;
                $display("FAIL %s missed slot cyc=%0d now=%0d", m_e.name, m_e.cyc, cyc);
            end
        end
    end

    initial begin
        // reset from power-up
        step(2);
        push(3, "rst_init", 0, 0, 0, 0, 4'd0);
        step(1);
        RESETN = 1'b1;
        push(4, "idle_after_rst", 0, 0, 0, 0, 4'd0);
        step(1);

        // test 1: reset while running
        b = cyc;
        EN = 1'b1; MODE = 1'b0; HI_LEN = 4'd1; LO_LEN = 4'd1; START = 1'b1;
        push(b + 4, "t1_run_tick", 1, 1, 0, 1, 4'd0);
        push(b + 6, "t1_run_low", 0, 1, 0, 0, 4'd0);
        push(b + 7, "t1_rst_a", 0, 0, 0, 0, 4'd0);
        push(b + 8, "t1_rst_b", 0, 0, 0, 0, 4'd0);
        push(b + 9, "t1_rst_rel", 0, 0, 0, 0, 4'd0);
        step(1);
        START = 1'b0;
        step(5);
        RESETN = 1'b0;
        step(2);
        RESETN = 1'b1;
        step(1);

        // test 2: one-shot HI=2 LO=3
        b = cyc;
        MODE = 1'b1; HI_LEN = 4'd2; LO_LEN = 4'd3; START = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            if (k <= 8)
                push(b + k, "t2_high", 1, 1, 0, (k % 4 == 0), 4'((k - 1) / 4));
            else if (k <= 20)
                push(b + k, "t2_low", 0, 1, 0, (k % 4 == 0), 4'((k - 9) / 4));
            else if (k == 21)
                push(b + k, "t2_done", 0, 0, 1, 0, 4'd0);
            else
                push(b + k, "t2_idle", 0, 0, 0, 0, 4'd0);
        end
        step(1);
        START = 1'b0;
        step(21);

        // test 3: continuous HI=1 LO=1, STOP coincides with period end
        b = cyc;
        MODE = 1'b0; HI_LEN = 4'd1; LO_LEN = 4'd1; START = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            if (k <= 24)
                push(b + k, "t3_cont", (((k - 1) / 4) % 2 == 0), 1,
                     (k > 1 && (k - 1) % 8 == 0), (k % 4 == 0), 4'd0);
            else
                push(b + k, "t3_stop", 0, 0, 0, 0, 4'd0);
        end
        step(1);
        START = 1'b0;
        step(23);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        step(1);

        // test 4: zero lengths behave as one
        b = cyc;
        MODE = 1'b1; HI_LEN = 4'd0; LO_LEN = 4'd0; START = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 4)
                push(b + k, "t4_high", 1, 1, 0, (k == 4), 4'd0);
            else if (k <= 8)
                push(b + k, "t4_low", 0, 1, 0, (k == 8), 4'd0);
            else if (k == 9)
                push(b + k, "t4_done", 0, 0, 1, 0, 4'd0);
            else
                push(b + k, "t4_idle", 0, 0, 0, 0, 4'd0);
        end
        step(1);
        START = 1'b0;
        step(9);

        // test 5: pause for 5 cycles in HIGH
        b = cyc;
        MODE = 1'b1; HI_LEN = 4'd2; LO_LEN = 4'd1; START = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            if (k <= 13)
                push(b + k, "t5_high", 1, 1, 0, (k == 9 || k == 13), (k >= 10) ? 4'd1 : 4'd0);
            else if (k <= 17)
                push(b + k, "t5_low", 0, 1, 0, (k == 17), 4'd0);
            else if (k == 18)
                push(b + k, "t5_done", 0, 0, 1, 0, 4'd0);
            else
                push(b + k, "t5_idle", 0, 0, 0, 0, 4'd0);
        end
        step(1);
        START = 1'b0;
        step(1);
        EN = 1'b0;
        step(5);
        EN = 1'b1;
        step(12);

        // test 6a: START and STOP together in IDLE
        b = cyc;
        START = 1'b1; STOP = 1'b1;
        push(b + 1, "t6_startstop", 0, 0, 0, 0, 4'd0);
        push(b + 2, "t6_startstop2", 0, 0, 0, 0, 4'd0);
        step(1);
        START = 1'b0; STOP = 1'b0;
        step(1);

        // test 6b: restart and length change ignored mid-HIGH, STOP in LOW
        b = cyc;
        MODE = 1'b1; HI_LEN = 4'd1; LO_LEN = 4'd3; START = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4)
                push(b + k, "t6_high", 1, 1, 0, (k == 4), 4'd0);
            else if (k <= 6)
                push(b + k, "t6_low", 0, 1, 0, 0, 4'd0);
            else
                push(b + k, "t6_stopped", 0, 0, 0, 0, 4'd0);
        end
        step(1);
        START = 1'b0;
        step(1);
        HI_LEN = 4'd5; START = 1'b1;
        step(1);
        START = 1'b0;
        step(3);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        step(1);

        for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
